// File: rtl/moter_pkg.sv
// Shared speed-state encoding and mux select codes for the motor speed selector.
package moter_pkg;

    typedef enum logic [2:0] {
        STOP = 3'd0,
        SPD1 = 3'd1,
        SPD2 = 3'd2,
        SPD3 = 3'd3,
        SPD4 = 3'd4
    } state_e;

    localparam logic [3:0] SEL_STOP = 4'b0000;
    localparam logic [3:0] SEL_SPD1 = 4'b0001;
    localparam logic [3:0] SEL_SPD2 = 4'b0010;
    localparam logic [3:0] SEL_SPD3 = 4'b0100;
    localparam logic [3:0] SEL_SPD4 = 4'b1000;

    function automatic logic [3:0] sel_code(input state_e s);
        logic [3:0] code;
        code = SEL_STOP;
        case (s)
            SPD1:    code = SEL_SPD1;
            SPD2:    code = SEL_SPD2;
            SPD3:    code = SEL_SPD3;
            SPD4:    code = SEL_SPD4;
            default: code = SEL_STOP;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// Push-button front end: 2-flop synchronizer, stability counter, one-cycle
// press pulse on the rising edge of the debounced level.
module btn_debounce #(
    parameter int DEB_CNT = 1_000_000
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_btn,
    output logic o_press
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    logic          sync1_q, sync2_q;
    logic          deb_q, deb_d;
    logic          deb_dly_q;
    logic          press_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Only two levels exist, so any sample equal to the debounced level is a
    // change away from the candidate level and restarts the count.
    always_comb begin
        cnt_d = '0;
        deb_d = deb_q;
        if (sync2_q != deb_q) begin
            if (cnt_q == CNT_MAX) deb_d = sync2_q;
            else                  cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            cnt_q     <= '0;
            deb_q     <= 1'b0;
            deb_dly_q <= 1'b0;
            press_q   <= 1'b0;
        end else begin
            sync1_q   <= i_btn;
            sync2_q   <= sync1_q;
            cnt_q     <= cnt_d;
            deb_q     <= deb_d;
            deb_dly_q <= deb_q;
            press_q   <= deb_q & ~deb_dly_q;
        end
    end

    assign o_press = press_q;

endmodule

// File: rtl/moter_speed_ctrl.sv
// Five-level motor speed selector: debounced buttons drive the speed FSM,
// fixed-duty PWM waveforms plus a glitch-free select code feed the PWM mux.
module moter_speed_ctrl
    import moter_pkg::*;
#(
    parameter int PERIOD  = 100_000,
    parameter int DEB_CNT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       i_btn_up,
    input  logic       i_btn_down,
    input  logic       i_btn_stop,
    output logic [4:0] o_pwm,
    output logic [3:0] o_sel,
    output logic [2:0] o_state
);

    localparam int CW  = $clog2(PERIOD);
    localparam int QTR = PERIOD / 4;
    localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);

    logic          up_p, down_p, stop_p;
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    sel_q, sel_d;
    logic [4:0]    pwm_q, pwm_d;

    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_up (
        .clk(clk), .reset_n(reset_n), .i_btn(i_btn_up), .o_press(up_p)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_down (
        .clk(clk), .reset_n(reset_n), .i_btn(i_btn_down), .o_press(down_p)
    );
    btn_debounce #(.DEB_CNT(DEB_CNT)) u_deb_stop (
        .clk(clk), .reset_n(reset_n), .i_btn(i_btn_stop), .o_press(stop_p)
    );

    // Thresholds are elaboration constants; the end duties need no compare.
    for (genvar k = 0; k < 5; k++) begin : g_duty
        if (k == 0) begin : g_zero
            assign pwm_d[k] = 1'b0;
        end else if (k == 4) begin : g_full
            assign pwm_d[k] = 1'b1;
        end else begin : g_cmp
            localparam logic [CW:0] THR = (CW+1)'(k * QTR);
            assign pwm_d[k] = ({1'b0, cnt_q} < THR);
        end
    end

    always_comb begin
        state_d = state_q;
        if (stop_p) begin
            state_d = STOP;
        end else if (up_p && !down_p) begin
            if (state_q != SPD4) state_d = state_e'(state_q + 3'd1);
        end else if (down_p && !up_p) begin
            if (state_q != STOP) state_d = state_e'(state_q - 3'd1);
        end
    end

    // Select only moves at the period boundary so the mux never emits a runt;
    // STOP bypasses that so the motor cuts out immediately.
    always_comb begin
        cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        sel_d = sel_q;
        if (state_q == STOP)          sel_d = SEL_STOP;
        else if (cnt_q == CNT_LAST)   sel_d = sel_code(state_q);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= STOP;
            cnt_q   <= '0;
            sel_q   <= SEL_STOP;
            pwm_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            pwm_q   <= pwm_d;
        end
    end

    assign o_pwm   = pwm_q;
    assign o_sel   = sel_q;
    assign o_state = state_q;

endmodule

// File: tb/tb_moter_speed_ctrl.sv
// Directed bench for moter_speed_ctrl with PERIOD = 8, DEB_CNT = 4.
module tb_moter_speed_ctrl;

    localparam int PERIOD  = 8;
    localparam int DEB_CNT = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       up = 1'b0, dn = 1'b0, stp = 1'b0;
    logic [4:0] o_pwm;
    logic [3:0] o_sel;
    logic [2:0] o_state;

    int         n_vec = 0;
    int         n_err = 0;
    int         ph = 0;       // expected cnt value after the latest edge
    bit         live = 1'b0;
    logic [3:0] prev_sel = 4'b0;

    always #5 clk = ~clk;

    moter_speed_ctrl #(.PERIOD(PERIOD), .DEB_CNT(DEB_CNT)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .i_btn_up  (up),
        .i_btn_down(dn),
        .i_btn_stop(stp),
        .o_pwm     (o_pwm),
        .o_sel     (o_sel),
        .o_state   (o_state)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance n edges; o_pwm is checked every cycle against the counter phase,
    // and any o_sel change must land on cnt==0 unless it is the drop to STOP.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            logic [4:0] exp_pwm;
            bit         r;
            @(posedge clk);
            r = reset_n;
            if (!r) exp_pwm = 5'b00000;
            else    exp_pwm = {1'b1, ph < 6, ph < 4, ph < 2, 1'b0};
            ph = r ? (ph + 1) % PERIOD : 0;
            #1;
            if (!r) live = 1'b1;
            if (live) begin
                chk("pwm", 32'(o_pwm), 32'(exp_pwm));
                if (o_sel !== prev_sel)
                    chk("sel_chg_phase", (o_sel == 4'b0000) ? 0 : ph, 0);
            end
            prev_sel = o_sel;
        end
    endtask

    initial begin
        int         hi1, hi2, hi3;
        int         st_tab [5];
        logic [3:0] sel_tab [5];
        st_tab  = '{1, 2, 3, 4, 4};
        sel_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1000};

        // reset and first period
        reset_n = 1'b0;
        step(3);
        chk("rst_state", 32'(o_state), 0);
        chk("rst_sel",   32'(o_sel),   0);
        chk("rst_pwm",   32'(o_pwm),   0);
        reset_n = 1'b1;
        step(1);
        chk("first_pwm", 32'(o_pwm), 32'(5'b11110));
        hi1 = 0; hi2 = 0; hi3 = 0;
        for (int i = 0; i < PERIOD; i++) begin
            step(1);
            hi1 += int'(o_pwm[1]);
            hi2 += int'(o_pwm[2]);
            hi3 += int'(o_pwm[3]);
        end
        chk("duty25", hi1, 2);
        chk("duty50", hi2, 4);
        chk("duty75", hi3, 6);

        // five clean up presses, saturating at SPD4
        for (int p = 0; p < 5; p++) begin
            up = 1'b1;
            step(7);
            chk("up_hold", 32'(o_state), (p == 0) ? 0 : st_tab[p-1]);
            step(1);
            chk("up_step", 32'(o_state), st_tab[p]);
            up = 1'b0;
            step(8);
            chk("up_sel", 32'(o_sel), 32'(sel_tab[p]));
        end

        // down to SPD3
        dn = 1'b1;
        step(8);
        chk("down_step", 32'(o_state), 3);
        dn = 1'b0;
        step(8);
        chk("down_sel", 32'(o_sel), 32'(4'b0100));

        // stop mid-period: state drops at cnt=2, select one cycle later
        for (int i = 0; i < PERIOD && ph != 2; i++) step(1);
        stp = 1'b1;
        step(7);
        chk("stop_hold", 32'(o_state), 3);
        step(1);
        chk("stop_state", 32'(o_state), 0);
        chk("stop_sel_prev", 32'(o_sel), 32'(4'b0100));
        step(1);
        chk("stop_sel", 32'(o_sel), 0);
        stp = 1'b0;
        step(8);

        // down saturates at STOP
        dn = 1'b1;
        step(8);
        chk("down_sat", 32'(o_state), 0);
        dn = 1'b0;
        step(8);

        // bouncing up input, then held
        for (int i = 0; i < 5; i++) begin
            up = 1'b1; step(2);
            up = 1'b0; step(2);
        end
        chk("bounce_none", 32'(o_state), 0);
        up = 1'b1;
        step(7);
        chk("bounce_hold", 32'(o_state), 0);
        step(1);
        chk("bounce_one", 32'(o_state), 1);
        step(16);
        chk("held_single", 32'(o_state), 1);
        up = 1'b0;
        step(8);
        chk("bounce_sel", 32'(o_sel), 32'(4'b0001));

        // simultaneous presses
        up = 1'b1;
        step(8);
        chk("to_spd2", 32'(o_state), 2);
        up = 1'b0;
        step(8);
        up = 1'b1; dn = 1'b1;
        step(8);
        chk("updown_same", 32'(o_state), 2);
        step(8);
        chk("updown_held", 32'(o_state), 2);
        up = 1'b0; dn = 1'b0;
        step(8);
        chk("updown_sel", 32'(o_sel), 32'(4'b0010));
        up = 1'b1; stp = 1'b1;
        step(8);
        chk("upstop_state", 32'(o_state), 0);
        step(1);
        chk("upstop_sel", 32'(o_sel), 0);
        up = 1'b0; stp = 1'b0;
        step(8);
        chk("upstop_after", 32'(o_state), 0);

        // reset during qualification discards the partial count
        up = 1'b1;
        step(4);
        reset_n = 1'b0;
        step(1);
        chk("rst2_state", 32'(o_state), 0);
        chk("rst2_sel",   32'(o_sel),   0);
        reset_n = 1'b1;
        step(7);
        chk("requal_hold", 32'(o_state), 0);
        step(1);
        chk("requal_step", 32'(o_state), 1);
        step(8);
        chk("requal_single", 32'(o_state), 1);
        up = 1'b0;
        step(8);
        chk("requal_sel", 32'(o_sel), 32'(4'b0001));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/moter_speed_ctrl.md
# moter_speed_ctrl

Speed-selection front end for the PWM motor path. Debounces three push-buttons (up, down, stop) and steps a five-level speed state machine. Generates the five fixed-duty PWM waveforms (0/25/50/75/100 %) and the matching select code. Its outputs feed the downstream 5:1 PWM select mux directly (`o_pwm` → mux data inputs, `o_sel` → mux select).

## Interface
Parameters:
- `PERIOD`, 100_000: PWM period in clk cycles; must be a multiple of 4 and ≥ 4.
- `DEB_CNT`, 1_000_000: cycles a synchronized button level must stay stable before it is accepted.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `i_btn_up`  in  1  raw button, asynchronous, active-high.
- `i_btn_down`  in  1  raw button, asynchronous, active-high.
- `i_btn_stop`  in  1  raw button, asynchronous, active-high.
- `o_pwm`  out  5  `o_pwm[k]` carries duty k·25 %, k = 0..4.
- `o_sel`  out  4  select code: STOP 4'b0000, SPD1 4'b0001, SPD2 4'b0010, SPD3 4'b0100, SPD4 4'b1000.
- `o_state`  out  3  current speed state 0..4, for LEDs/debug.

## Operation
- **Button front end, per button:**
  - 2-flop synchronizer.
  - Stability counter: reloads on any change of the synchronized level; the debounced level updates after DEB_CNT consecutive equal samples.
  - Rising edge of the debounced level → one-cycle press pulse.
  - A held button produces exactly one pulse.
- **FSM states:** STOP(0), SPD1(1), SPD2(2), SPD3(3), SPD4(4).
  - stop pulse → STOP from any state.
  - up pulse → state+1, saturating at SPD4.
  - down pulse → state−1, saturating at STOP.
  - Priority: stop beats up/down. If up and down pulse in the same cycle, the state is unchanged.
- **PWM counter:**
  - `cnt` counts 0..PERIOD−1 and wraps to 0.
  - `o_pwm[k]` = registered (`cnt` < k·PERIOD/4).
  - `o_pwm[0]` is constant 0; `o_pwm[4]` is constant 1 after reset.
  - Duty thresholds are computed at elaboration. There is no runtime multiply.
- **Select update:**
  - `o_sel` follows the FSM state only at the period boundary: it loads when `cnt` == PERIOD−1, visible from the cycle `cnt` = 0. This prevents runt pulses at the mux output.
  - Exception: a transition to STOP loads `o_sel` = 4'b0000 on the next cycle, regardless of `cnt`.
  - `o_state` tracks the FSM immediately.

## Timing
- **Reset** (`reset_n` low at a clk edge), values on the next cycle:
  - `cnt` = 0, FSM = STOP, `o_sel` = 4'b0000, `o_state` = 0, `o_pwm` = 5'b00000.
  - Synchronizers, debounced levels and stability counters cleared.
- **Reset mid-operation:** an in-flight debounce is discarded. A button still held at release of reset must be re-qualified for DEB_CNT cycles, and produces one pulse.
- **First cycle after reset release:** `o_pwm` = {1,1,1,1,0} (`cnt` = 0 is below every non-zero threshold).
- **Button latency:** raw edge → press pulse = 2 (sync) + DEB_CNT + 1 cycles.
- **Press pulse → FSM / `o_state` update:** +1 cycle.
- **`o_sel` update:**
  - STOP: +1 cycle after the FSM.
  - Other states: at the next `cnt` == PERIOD−1 edge, worst case PERIOD cycles.
- **`o_pwm` latency:** one register stage after `cnt`. `o_pwm[k]` is high for exactly k·PERIOD/4 cycles per period.
- **Several state changes within one period:** only the state present at the boundary reaches `o_sel`.

## Structure
- Package `moter_pkg`:
  - state enum / localparams STOP..SPD4.
  - `SEL_CODE` constants (4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000).
  - Function mapping state → select code.
- Sub-module `btn_debounce`:
  - Parameter DEB_CNT; ports `clk`, `reset_n`, `i_btn`, `o_press`.
  - Instantiated three times.
- The FSM, PWM counter and select register live in the top level.

## Test plan
All scenarios use PERIOD = 8, DEB_CNT = 4.
1. **Reset:** hold `reset_n` low 3 cycles, release → `o_sel` = 0000, `o_state` = 0, `o_pwm` = 11110 on the first cycle, then `o_pwm[2]` high exactly 4 of every 8 cycles.
2. **Step up:** clean up presses ×5 → `o_state` 1,2,3,4,4 (saturates). `o_sel` reaches 1000, changing only at `cnt` = 0 boundaries.
3. **Bounce:** up input toggling every 2 cycles for 20 cycles, then held high → exactly one press pulse, 7 cycles after the final rising edge; `o_state` increments once.
4. **Stop in mid-period:** from SPD3 at `cnt` = 2, stop press → `o_sel` = 0000 one cycle after `o_state` = 0, without waiting for the boundary.
5. **Simultaneous pulses:** up+down in the same cycle from SPD2 → state stays 2. Up+stop in the same cycle → STOP.
6. **Reset during debounce:** assert `reset_n` low for 1 cycle while up is held 2 cycles into qualification, keeping up held → no pulse before 7 cycles after reset release, then exactly one pulse; state = SPD1.
